// File: rtl/irq_claim_ctrl_if.sv
// Config and claim/nesting signals between the interrupt claim controller and the core.
// The controller takes the slave side; the core (or bench) takes the master side.
interface irq_claim_ctrl_if #(
    parameter int unsigned NrIrqs    = 32,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned NestDepth = 4
);
    localparam int unsigned IdxWidth   = $clog2(NrIrqs);
    localparam int unsigned DepthWidth = $clog2(NestDepth + 1);

    logic                  cfg_we;
    logic [IdxWidth-1:0]   cfg_idx;
    logic                  cfg_en;
    logic [PrioWidth-1:0]  cfg_prio;
    logic                  claim_valid;
    logic                  claim_ready;
    logic [IdxWidth-1:0]   claim_id;
    logic [PrioWidth-1:0]  claim_prio;
    logic                  done;
    logic [PrioWidth-1:0]  level;
    logic [DepthWidth-1:0] depth;

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_prio, claim_ready, done,
        input  claim_valid, claim_id, claim_prio, level, depth
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_prio, claim_ready, done,
        output claim_valid, claim_id, claim_prio, level, depth
    );
endinterface

// File: rtl/irq_claim_ctrl.sv
// Interrupt claim/nesting controller: edge-latched pending lines, per-line enable/priority,
// highest-priority offer over a valid/ready claim, and a priority stack for preemption.
module irq_claim_ctrl #(
    parameter int unsigned NrIrqs    = 32,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned NestDepth = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NrIrqs-1:0] irq_i,
    irq_claim_ctrl_if.slave   bus
);
    localparam int unsigned IdxWidth   = $clog2(NrIrqs);
    localparam int unsigned DepthWidth = $clog2(NestDepth + 1);
    localparam logic [DepthWidth-1:0] MaxDepth = DepthWidth'(NestDepth);

    typedef enum logic {StIdle, StOffer} state_e;

    state_e                state_q;
    logic [NrIrqs-1:0]     irq_q;
    logic [NrIrqs-1:0]     pending_q;
    logic [NrIrqs-1:0]     pending_d;
    logic [NrIrqs-1:0]     en_q;
    logic [PrioWidth-1:0]  prio_q [NrIrqs];
    // stack_q[0] is the running level; vacated entries are zeroed so an empty stack reads 0
    logic [PrioWidth-1:0]  stack_q [NestDepth];
    logic [DepthWidth-1:0] depth_q;
    logic                  valid_q;
    logic [IdxWidth-1:0]   id_q;
    logic [PrioWidth-1:0]  offer_prio_q;

    logic [PrioWidth-1:0]  level;
    logic [PrioWidth-1:0]  best_prio;
    logic [IdxWidth-1:0]   best_idx;
    logic                  handshake;
    logic                  pop;

    assign level     = stack_q[0];
    assign handshake = valid_q & bus.claim_ready;
    assign pop       = bus.done & (depth_q != '0);

    // Ascending scan with strict compare keeps the lowest index on equal priority
    always_comb begin
        best_prio = '0;
        best_idx  = '0;
        for (int i = 0; i < NrIrqs; i++) begin
            if (pending_q[i] && en_q[i] && (prio_q[i] > level) && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_idx  = IdxWidth'(i);
            end
        end
    end

    // A new edge on the line being claimed wins over the clear
    always_comb begin
        pending_d = pending_q;
        if (handshake) begin
            pending_d[id_q] = 1'b0;
        end
        pending_d = pending_d | (irq_i & ~irq_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            irq_q        <= '0;
            pending_q    <= '0;
            en_q         <= '0;
            depth_q      <= '0;
            valid_q      <= 1'b0;
            id_q         <= '0;
            offer_prio_q <= '0;
            for (int i = 0; i < NrIrqs; i++) begin
                prio_q[i] <= '0;
            end
            for (int k = 0; k < NestDepth; k++) begin
                stack_q[k] <= '0;
            end
        end else begin
            irq_q     <= irq_i;
            pending_q <= pending_d;

            if (bus.cfg_we) begin
                en_q[bus.cfg_idx]   <= bus.cfg_en;
                prio_q[bus.cfg_idx] <= bus.cfg_prio;
            end

            if (handshake && pop) begin
                stack_q[0] <= offer_prio_q;
            end else if (handshake) begin
                for (int k = NestDepth - 1; k > 0; k--) begin
                    stack_q[k] <= stack_q[k-1];
                end
                stack_q[0] <= offer_prio_q;
                depth_q    <= depth_q + 1'b1;
            end else if (pop) begin
                for (int k = 0; k < NestDepth - 1; k++) begin
                    stack_q[k] <= stack_q[k+1];
                end
                stack_q[NestDepth-1] <= '0;
                depth_q              <= depth_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if ((best_prio != '0) && (depth_q < MaxDepth)) begin
                        state_q      <= StOffer;
                        valid_q      <= 1'b1;
                        id_q         <= best_idx;
                        offer_prio_q <= best_prio;
                    end
                end
                StOffer: begin
                    if (bus.claim_ready) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.claim_valid = valid_q;
    assign bus.claim_id    = id_q;
    assign bus.claim_prio  = offer_prio_q;
    assign bus.level       = level;
    assign bus.depth       = depth_q;
endmodule
